// File: rtl/jtbubl_gfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtbubl_gfx_pkg
//  Purpose  : Shared types and defaults for the gfx ROM slot.
//             - gfx_state_t : fetch FSM state encoding
//             - c_aw        : default slot word address width (32-bit words)
//             - c_saw       : default SDRAM address width (16-bit words)
//             - c_offset    : default SDRAM base of the gfx region
//  Revision : 1.0 - initial release
// ============================================================================
package jtbubl_gfx_pkg;

  localparam int          c_aw     = 18;
  localparam int          c_saw    = 22;
  localparam logic [21:0] c_offset = 22'h10_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } gfx_state_t;

endpackage
`default_nettype wire

// File: rtl/jtbubl_gfx_rom_slot_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtbubl_gfx_slot_if / jtbubl_gfx_sdram_if
//  Purpose  : Bus bundles for the gfx ROM slot.
//             jtbubl_gfx_slot_if  : video-side ROM port
//               slot_cs, slot_addr (master -> slave)
//               slot_dout, slot_ok (slave -> master)
//             jtbubl_gfx_sdram_if : SDRAM controller port
//               sdram_req, sdram_addr          (master -> slave)
//               sdram_ack, sdram_dst, sdram_din (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface jtbubl_gfx_slot_if #(
  parameter int AW = 18
);
  logic          slot_cs;
  logic [AW-1:0] slot_addr;
  logic [31:0]   slot_dout;
  logic          slot_ok;

  modport master (output slot_cs, output slot_addr, input  slot_dout, input  slot_ok);
  modport slave  (input  slot_cs, input  slot_addr, output slot_dout, output slot_ok);
endinterface

interface jtbubl_gfx_sdram_if #(
  parameter int SAW = 22
);
  logic           sdram_req;
  logic [SAW-1:0] sdram_addr;
  logic           sdram_ack;
  logic           sdram_dst;
  logic [15:0]    sdram_din;

  modport master (output sdram_req, output sdram_addr,
                  input  sdram_ack, input  sdram_dst, input sdram_din);
  modport slave  (input  sdram_req, input  sdram_addr,
                  output sdram_ack, output sdram_dst, output sdram_din);
endinterface
`default_nettype wire

// File: rtl/jtbubl_gfx_tagmem.sv
`default_nettype none
// ============================================================================
//  Module   : jtbubl_gfx_tagmem
//  Purpose  : Tag/valid/data storage with hit compare for the gfx ROM slot.
//             Single entry by default; two entries with one LRU bit when
//             JTBUBL_GFX_CACHE2_EN is defined.
//  Ports    : clk, rst_n      clock, async active-low reset
//             lookup_addr     address compared against stored tags
//             touch           lookup hit was consumed (updates LRU)
//             fill            write fill_addr/fill_data into the victim entry
//             fill_addr       tag to store
//             fill_data       32-bit word to store
//             hit             lookup_addr matches a valid entry
//             dout            data of the hitting entry (entry 0 otherwise)
//  Revision : 1.0 - initial release
// ============================================================================
module jtbubl_gfx_tagmem #(
  parameter int AW = 18
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [AW-1:0] lookup_addr,
  input  wire logic          touch,
  input  wire logic          fill,
  input  wire logic [AW-1:0] fill_addr,
  input  wire logic [31:0]   fill_data,
  output logic               hit,
  output logic [31:0]        dout
);

`ifdef JTBUBL_GFX_CACHE2_EN

  logic [1:0]         r_valid;
  logic [AW-1:0]      r_tag  [2];
  logic [31:0]        r_data [2];
  logic               r_lru;      // index of the least recently used entry
  logic [1:0]         w_hit;

  for (genvar g = 0; g < 2; g++) begin : g_cmp
    assign w_hit[g] = r_valid[g] && (r_tag[g] == lookup_addr);
  end

  assign hit  = |w_hit;
  assign dout = w_hit[1] ? r_data[1] : r_data[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 2'b00;
      r_lru   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (fill) begin
      r_valid[r_lru] <= 1'b1;
      r_tag[r_lru]   <= fill_addr;
      r_data[r_lru]  <= fill_data;
      r_lru          <= ~r_lru;   // the filled entry becomes MRU
    end else if (touch && hit) begin
      r_lru <= ~w_hit[1];         // hit on entry 1 leaves entry 0 as LRU
    end
  end

`else

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [31:0]   r_data;
  logic          w_unused_touch;

  // With one entry there is no replacement choice to track.
  assign w_unused_touch = touch;

  assign hit  = r_valid && (r_tag == lookup_addr);
  assign dout = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (fill) begin
      r_valid <= 1'b1;
      r_tag   <= fill_addr;
      r_data  <= fill_data;
    end
  end

`endif

endmodule
`default_nettype wire

// File: rtl/jtbubl_gfx_rom_slot.sv
`default_nettype none
// ============================================================================
//  Module   : jtbubl_gfx_rom_slot
//  Purpose  : SDRAM-side responder for the video gfx ROM port. A 32-bit word
//             is fetched as two 16-bit SDRAM beats (low half first) from the
//             region starting at OFFSET. A tag cache answers repeated reads
//             with zero latency. Define JTBUBL_GFX_CACHE2_EN for a two-entry
//             LRU cache instead of the single entry.
//  Ports    : clk    system clock
//             rst_n  asynchronous reset, active low
//             slot   video-side ROM port (slave modport)
//             sdram  SDRAM controller port (master modport)
//  Revision : 1.0 - initial release
// ============================================================================
module jtbubl_gfx_rom_slot
  import jtbubl_gfx_pkg::*;
#(
  parameter int             AW     = c_aw,
  parameter int             SAW    = c_saw,
  parameter logic [SAW-1:0] OFFSET = SAW'(c_offset)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  jtbubl_gfx_slot_if.slave   slot,
  jtbubl_gfx_sdram_if.master sdram
);

  gfx_state_t    r_state;
  logic          r_req;
  logic [AW-1:0] r_fetch_addr;
  logic [15:0]   r_lo;

  logic          w_hit;
  logic          w_idle;
  logic          w_ok;
  logic          w_fill;
  logic [31:0]   w_cache_dout;

  assign w_idle = (r_state == ST_IDLE);
  assign w_ok   = slot.slot_cs && w_hit && w_idle;
  assign w_fill = (r_state == ST_BEAT1) && sdram.sdram_dst;

  // The fetch register only changes when leaving IDLE, so the SDRAM address
  // holds steady for the whole transaction. Sum wraps modulo 2^SAW.
  assign sdram.sdram_addr = OFFSET + SAW'({r_fetch_addr, 1'b0});
  assign sdram.sdram_req  = r_req;
  assign slot.slot_ok     = w_ok;
  assign slot.slot_dout   = w_cache_dout;

  jtbubl_gfx_tagmem #(
    .AW (AW)
  ) u_tagmem (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_addr (slot.slot_addr),
    .touch       (w_ok),
    .fill        (w_fill),
    .fill_addr   (r_fetch_addr),
    .fill_data   ({sdram.sdram_din, r_lo}),
    .hit         (w_hit),
    .dout        (w_cache_dout)
  );

  // A started fetch always runs to completion: the controller cannot cancel
  // an accepted request, and the fetched word still lands in the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_fetch_addr <= '0;
      r_lo         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (slot.slot_cs && !w_hit) begin
            r_fetch_addr <= slot.slot_addr;
            r_req        <= 1'b1;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram.sdram_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          if (sdram.sdram_dst) begin
            r_lo    <= sdram.sdram_din;
            r_state <= ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          if (sdram.sdram_dst) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_gfx_rom_slot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtbubl_gfx_rom_slot
//  Purpose  : Directed self-checking bench for jtbubl_gfx_rom_slot. The
//             SDRAM controller is played by hand from each scenario task.
//             Covers JTBUBL_GFX_CACHE2_EN in both settings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtbubl_gfx_rom_slot;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  jtbubl_gfx_slot_if  #(.AW(18))  slot_bus  ();
  jtbubl_gfx_sdram_if #(.SAW(22)) sdram_bus ();

  jtbubl_gfx_rom_slot dut (
    .clk   (clk),
    .rst_n (rst_n),
    .slot  (slot_bus),
    .sdram (sdram_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    slot_bus.slot_cs    = 1'b0;
    slot_bus.slot_addr  = '0;
    sdram_bus.sdram_ack = 1'b0;
    sdram_bus.sdram_dst = 1'b0;
    sdram_bus.sdram_din = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drives one complete miss: waits (bounded) for the request, then acks
  // and supplies two beats. Leaves the DUT back in IDLE with cs held.
  task automatic fetch(input logic [17:0] a, input logic [15:0] lo, input logic [15:0] hi);
    int n;
    slot_bus.slot_cs   = 1'b1;
    slot_bus.slot_addr = a;
    n = 0;
    while (!sdram_bus.sdram_req && n < 8) begin
      tick();
      n++;
    end
    tests++;
    if (sdram_bus.sdram_req !== 1'b1) begin
      $display("FAIL fetch_req_timeout addr=%h: got req=%b, want 1", a, sdram_bus.sdram_req);
      fails++;
    end
    sdram_bus.sdram_ack = 1'b1;
    tick();
    sdram_bus.sdram_ack = 1'b0;
    sdram_bus.sdram_dst = 1'b1;
    sdram_bus.sdram_din = lo;
    tick();
    sdram_bus.sdram_din = hi;
    tick();
    sdram_bus.sdram_dst = 1'b0;
    sdram_bus.sdram_din = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    slot_bus.slot_cs    = 1'b0;
    slot_bus.slot_addr  = '0;
    sdram_bus.sdram_ack = 1'b0;
    sdram_bus.sdram_dst = 1'b0;
    sdram_bus.sdram_din = '0;
    #2;
    tests++;
    if (sdram_bus.sdram_req !== 1'b0) begin
      $display("FAIL reset_req: got %b, want 0", sdram_bus.sdram_req); fails++;
    end
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL reset_ok: got %b, want 0", slot_bus.slot_ok); fails++;
    end
    tests++;
    if (slot_bus.slot_dout !== 32'h0) begin
      $display("FAIL reset_dout: got %h, want 00000000", slot_bus.slot_dout); fails++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_miss_fill();
    slot_bus.slot_cs   = 1'b1;
    slot_bus.slot_addr = 18'h00010;
    #1;
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL miss_ok_low: got %b, want 0", slot_bus.slot_ok); fails++;
    end
    tick();
    tests++;
    if (sdram_bus.sdram_req !== 1'b1) begin
      $display("FAIL miss_req: got %b, want 1", sdram_bus.sdram_req); fails++;
    end
    tests++;
    if (sdram_bus.sdram_addr !== 22'h100020) begin
      $display("FAIL miss_sdram_addr: got %h, want 100020", sdram_bus.sdram_addr); fails++;
    end
    sdram_bus.sdram_ack = 1'b1;
    tick();
    sdram_bus.sdram_ack = 1'b0;
    tests++;
    if (sdram_bus.sdram_req !== 1'b0) begin
      $display("FAIL miss_req_drop: got %b, want 0", sdram_bus.sdram_req); fails++;
    end
    sdram_bus.sdram_dst = 1'b1;
    sdram_bus.sdram_din = 16'h1234;
    tick();
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL miss_ok_mid: got %b, want 0", slot_bus.slot_ok); fails++;
    end
    sdram_bus.sdram_din = 16'hABCD;
    tick();
    sdram_bus.sdram_dst = 1'b0;
    tests++;
    if (slot_bus.slot_ok !== 1'b1) begin
      $display("FAIL miss_ok_fill: got %b, want 1", slot_bus.slot_ok); fails++;
    end
    tests++;
    if (slot_bus.slot_dout !== 32'hABCD1234) begin
      $display("FAIL miss_dout: got %h, want abcd1234", slot_bus.slot_dout); fails++;
    end
  endtask

  task automatic test_hit();
    slot_bus.slot_cs = 1'b0;
    tick();
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL hit_ok_cs_low: got %b, want 0", slot_bus.slot_ok); fails++;
    end
    slot_bus.slot_cs   = 1'b1;
    slot_bus.slot_addr = 18'h00010;
    #1;
    tests++;
    if (slot_bus.slot_ok !== 1'b1) begin
      $display("FAIL hit_ok_same_cycle: got %b, want 1", slot_bus.slot_ok); fails++;
    end
    tick();
    tests++;
    if (sdram_bus.sdram_req !== 1'b0) begin
      $display("FAIL hit_no_req: got %b, want 0", sdram_bus.sdram_req); fails++;
    end
  endtask

  task automatic test_addr_change();
    do_reset();
    slot_bus.slot_cs   = 1'b1;
    slot_bus.slot_addr = 18'h00010;
    tick();                           // -> REQ
    sdram_bus.sdram_ack = 1'b1;
    tick();                           // -> BEAT0
    sdram_bus.sdram_ack = 1'b0;
    slot_bus.slot_addr  = 18'h00011;
    tests++;
    if (sdram_bus.sdram_addr !== 22'h100020) begin
      $display("FAIL chg_addr_stable: got %h, want 100020", sdram_bus.sdram_addr); fails++;
    end
    sdram_bus.sdram_dst = 1'b1;
    sdram_bus.sdram_din = 16'h1111;
    tick();
    sdram_bus.sdram_din = 16'h2222;
    tick();                           // fill of 0x10 done, back in IDLE
    sdram_bus.sdram_dst = 1'b0;
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL chg_ok_low: got %b, want 0", slot_bus.slot_ok); fails++;
    end
    tick();                           // new miss issued
    tests++;
    if (sdram_bus.sdram_req !== 1'b1 || sdram_bus.sdram_addr !== 22'h100022) begin
      $display("FAIL chg_new_req: got req=%b addr=%h, want req=1 addr=100022",
               sdram_bus.sdram_req, sdram_bus.sdram_addr); fails++;
    end
    fetch(18'h00011, 16'h3333, 16'h4444);
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'h44443333) begin
      $display("FAIL chg_fill2: got ok=%b dout=%h, want ok=1 dout=44443333",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
    slot_bus.slot_addr = 18'h00010;
    #1;
`ifdef JTBUBL_GFX_CACHE2_EN
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'h22221111) begin
      $display("FAIL chg_first_kept: got ok=%b dout=%h, want ok=1 dout=22221111",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
`else
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL chg_first_evicted: got ok=%b, want 0", slot_bus.slot_ok); fails++;
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    fetch(18'h00010, 16'h5555, 16'h6666);
    slot_bus.slot_addr = 18'h00030;
    tick();                           // -> REQ
    sdram_bus.sdram_ack = 1'b1;
    tick();                           // -> BEAT0
    sdram_bus.sdram_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (sdram_bus.sdram_req !== 1'b0 || slot_bus.slot_ok !== 1'b0 || slot_bus.slot_dout !== 32'h0) begin
      $display("FAIL rst_beat0: got req=%b ok=%b dout=%h, want 0 0 00000000",
               sdram_bus.sdram_req, slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
    #2;
    rst_n = 1'b1;
    tick();                           // IDLE -> REQ for 0x30
    tests++;
    if (sdram_bus.sdram_req !== 1'b1) begin
      $display("FAIL rst_rereq: got %b, want 1", sdram_bus.sdram_req); fails++;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (sdram_bus.sdram_req !== 1'b0) begin
      $display("FAIL rst_req_async: got %b, want 0", sdram_bus.sdram_req); fails++;
    end
    #2;
    rst_n = 1'b1;
    slot_bus.slot_addr = 18'h00010;
    #1;
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL rst_cache_cleared: got ok=%b, want 0", slot_bus.slot_ok); fails++;
    end
    tick();
    tests++;
    if (sdram_bus.sdram_req !== 1'b1 || sdram_bus.sdram_addr !== 22'h100020) begin
      $display("FAIL rst_miss_again: got req=%b addr=%h, want req=1 addr=100020",
               sdram_bus.sdram_req, sdram_bus.sdram_addr); fails++;
    end
  endtask

  task automatic test_replacement();
    do_reset();
    fetch(18'h00001, 16'h0A01, 16'hA100);
    fetch(18'h00002, 16'h0B02, 16'hB200);
    slot_bus.slot_addr = 18'h00001;
    #1;
`ifdef JTBUBL_GFX_CACHE2_EN
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'hA1000A01) begin
      $display("FAIL lru_hit_a: got ok=%b dout=%h, want ok=1 dout=a1000a01",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
    tick();                           // hit on A makes B the LRU entry
    fetch(18'h00003, 16'h0C03, 16'hC300);
    slot_bus.slot_addr = 18'h00001;
    #1;
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'hA1000A01) begin
      $display("FAIL lru_a_kept: got ok=%b dout=%h, want ok=1 dout=a1000a01",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
    slot_bus.slot_addr = 18'h00003;
    #1;
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'hC3000C03) begin
      $display("FAIL lru_c_hit: got ok=%b dout=%h, want ok=1 dout=c3000c03",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
    slot_bus.slot_addr = 18'h00002;
    #1;
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL lru_b_evicted: got ok=%b, want 0", slot_bus.slot_ok); fails++;
    end
`else
    tests++;
    if (slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL single_a_evicted: got ok=%b, want 0", slot_bus.slot_ok); fails++;
    end
    slot_bus.slot_addr = 18'h00002;
    #1;
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'hB2000B02) begin
      $display("FAIL single_b_hit: got ok=%b dout=%h, want ok=1 dout=b2000b02",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
`endif
  endtask

  task automatic test_stray_strobes();
    do_reset();
    fetch(18'h00040, 16'h1111, 16'h2222);
    sdram_bus.sdram_dst = 1'b1;       // stray strobe while IDLE
    sdram_bus.sdram_din = 16'hFFFF;
    tick();
    sdram_bus.sdram_dst = 1'b0;
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'h22221111) begin
      $display("FAIL stray_dst_idle: got ok=%b dout=%h, want ok=1 dout=22221111",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
    slot_bus.slot_cs    = 1'b0;
    sdram_bus.sdram_ack = 1'b1;       // stray accept while IDLE
    tick();
    sdram_bus.sdram_ack = 1'b0;
    tests++;
    if (sdram_bus.sdram_req !== 1'b0) begin
      $display("FAIL stray_ack_idle: got req=%b, want 0", sdram_bus.sdram_req); fails++;
    end
    slot_bus.slot_cs   = 1'b1;
    slot_bus.slot_addr = 18'h3FFFF;   // top of the slot range
    tick();
    tests++;
    if (sdram_bus.sdram_addr !== 22'h17FFFE) begin
      $display("FAIL top_addr: got %h, want 17fffe", sdram_bus.sdram_addr); fails++;
    end
    sdram_bus.sdram_ack = 1'b1;
    tick();
    sdram_bus.sdram_ack = 1'b0;
    sdram_bus.sdram_dst = 1'b1;
    sdram_bus.sdram_din = 16'h3333;
    tick();                           // -> BEAT1
    sdram_bus.sdram_dst = 1'b0;
    sdram_bus.sdram_ack = 1'b1;       // stray accept while BEAT1
    tick();
    sdram_bus.sdram_ack = 1'b0;
    tests++;
    if (sdram_bus.sdram_req !== 1'b0 || slot_bus.slot_ok !== 1'b0) begin
      $display("FAIL stray_ack_beat1: got req=%b ok=%b, want 0 0",
               sdram_bus.sdram_req, slot_bus.slot_ok); fails++;
    end
    sdram_bus.sdram_dst = 1'b1;
    sdram_bus.sdram_din = 16'h4444;
    tick();
    sdram_bus.sdram_dst = 1'b0;
    tests++;
    if (slot_bus.slot_ok !== 1'b1 || slot_bus.slot_dout !== 32'h44443333) begin
      $display("FAIL stray_fill: got ok=%b dout=%h, want ok=1 dout=44443333",
               slot_bus.slot_ok, slot_bus.slot_dout); fails++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_miss_fill();
    test_hit();
    test_addr_change();
    test_reset_mid_fetch();
    test_replacement();
    test_stray_strobes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
